// File: rtl/rtc_time_counter.sv
// Time-of-day counter: prescales clk to a one-second tick and keeps 24-hour binary time
// with BCD display decode, validated loads, hour/minute adjust and a midnight pulse.
module rtc_time_counter #(
    parameter int TICK_DIV   = 50_000_000,
    parameter bit HOUR_12    = 1'b0,
    parameter int RESET_HOUR = 0,
    parameter int RESET_MIN  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       LD_time,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic       inc_hour,
    input  logic       inc_min,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       ld_err
);
    localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          sec_tick_q, sec_tick_d;
    logic          day_tick_q, day_tick_d;
    logic          ld_err_q, ld_err_d;

    logic          tick;
    logic          ld_valid;
    logic [5:0]    ld_hour;
    logic [5:0]    ld_min;
    logic [4:0]    disp_hour;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    assign tick     = run && (presc_q == PRESC_MAX);
    // Hour sum is kept 6 bits wide so 2,4..3,9 cannot alias into the valid range.
    assign ld_hour  = {4'd0, H_in1} * 6'd10 + {2'd0, H_in0};
    assign ld_min   = {2'd0, M_in1} * 6'd10 + {2'd0, M_in0};
    assign ld_valid = (H_in0 <= 4'd9) && (M_in1 <= 4'd5) && (M_in0 <= 4'd9) && (ld_hour <= 6'd23);

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path infers a latch.
        presc_d    = presc_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        sec_tick_d = 1'b0;
        day_tick_d = 1'b0;
        ld_err_d   = ld_err_q;

        if (run) presc_d = tick ? '0 : presc_q + PW'(1);

        if (LD_time) begin
            if (ld_valid) begin
                hour_d   = ld_hour[4:0];
                min_d    = ld_min;
                sec_d    = '0;
                presc_d  = '0;
                ld_err_d = 1'b0;
            end else begin
                presc_d  = presc_q;
                ld_err_d = 1'b1;
            end
        end else if (inc_hour || inc_min) begin
            if (inc_hour) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            if (inc_min)  min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end else if (tick) begin
            sec_tick_d = 1'b1;
            if (sec_q != 6'd59) begin
                sec_d = sec_q + 6'd1;
            end else begin
                sec_d = '0;
                if (min_q != 6'd59) begin
                    min_d = min_q + 6'd1;
                end else begin
                    min_d = '0;
                    if (hour_q != 5'd23) begin
                        hour_d = hour_q + 5'd1;
                    end else begin
                        hour_d     = '0;
                        day_tick_d = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            hour_q     <= 5'(RESET_HOUR);
            min_q      <= 6'(RESET_MIN);
            sec_q      <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
            ld_err_q   <= ld_err_d;
        end
    end

    always_comb begin
        disp_hour = hour_q;
        if (HOUR_12) begin
            if (hour_q == 5'd0)       disp_hour = 5'd12;
            else if (hour_q > 5'd12)  disp_hour = hour_q - 5'd12;
        end
    end

    assign hour     = hour_q;
    assign minute   = min_q;
    assign second   = sec_q;
    assign hour_bcd = to_bcd({1'b0, disp_hour});
    assign min_bcd  = to_bcd(min_q);
    assign sec_bcd  = to_bcd(sec_q);
    assign pm       = HOUR_12 && (hour_q >= 5'd12);
    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;
    assign ld_err   = ld_err_q;
endmodule

// File: tb/tb_rtc_time_counter.sv
// Bench for rtc_time_counter: a 24-hour and a 12-hour instance share stimulus and are
// compared every cycle against a seconds-of-day reference model.
module tb_rtc_time_counter;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0, LD_time = 1'b0, inc_hour = 1'b0, inc_min = 1'b0;
    logic [1:0] H_in1 = '0;
    logic [3:0] H_in0 = '0, M_in1 = '0, M_in0 = '0;

    logic [4:0] a_hour, b_hour;
    logic [5:0] a_minute, a_second, b_minute, b_second;
    logic [7:0] a_hour_bcd, a_min_bcd, a_sec_bcd, b_hour_bcd, b_min_bcd, b_sec_bcd;
    logic       a_pm, a_sec_tick, a_day_tick, a_ld_err;
    logic       b_pm, b_sec_tick, b_day_tick, b_ld_err;

    rtc_time_counter #(.TICK_DIV(TD), .HOUR_12(1'b0), .RESET_HOUR(7), .RESET_MIN(30)) dut24 (
        .clk(clk), .reset(reset), .run(run), .LD_time(LD_time),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .inc_hour(inc_hour), .inc_min(inc_min),
        .hour(a_hour), .minute(a_minute), .second(a_second),
        .hour_bcd(a_hour_bcd), .min_bcd(a_min_bcd), .sec_bcd(a_sec_bcd),
        .pm(a_pm), .sec_tick(a_sec_tick), .day_tick(a_day_tick), .ld_err(a_ld_err));

    rtc_time_counter #(.TICK_DIV(TD), .HOUR_12(1'b1), .RESET_HOUR(7), .RESET_MIN(30)) dut12 (
        .clk(clk), .reset(reset), .run(run), .LD_time(LD_time),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .inc_hour(inc_hour), .inc_min(inc_min),
        .hour(b_hour), .minute(b_minute), .second(b_second),
        .hour_bcd(b_hour_bcd), .min_bcd(b_min_bcd), .sec_bcd(b_sec_bcd),
        .pm(b_pm), .sec_tick(b_sec_tick), .day_tick(b_day_tick), .ld_err(b_ld_err));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int m_tod, m_presc;
    bit m_err, m_stick, m_dtick;

    typedef struct {
        logic [1:0] h1;
        logic [3:0] h0, m1, m0;
        bit         err;
        logic [7:0] h24, h12;
        bit         pm12;
        logic [7:0] mb;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    task automatic model_reset();
        m_tod = 7 * 3600 + 30 * 60;
        m_presc = 0;
        m_err = 0;
        m_stick = 0;
        m_dtick = 0;
    endtask

    task automatic model_step();
        int h, m, s;
        bit tk;
        tk = run && (m_presc == TD - 1);
        m_stick = 0;
        m_dtick = 0;
        h = m_tod / 3600;
        m = (m_tod / 60) % 60;
        s = m_tod % 60;
        if (LD_time) begin
            if (H_in0 <= 9 && M_in1 <= 5 && M_in0 <= 9 && int'(H_in1) * 10 + int'(H_in0) <= 23) begin
                m_tod = (int'(H_in1) * 10 + int'(H_in0)) * 3600 + (int'(M_in1) * 10 + int'(M_in0)) * 60;
                m_presc = 0;
                m_err = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            if (run) m_presc = (m_presc + 1) % TD;
            if (inc_hour || inc_min) begin
                if (inc_hour) h = (h + 1) % 24;
                if (inc_min)  m = (m + 1) % 60;
                m_tod = h * 3600 + m * 60 + s;
            end else if (tk) begin
                m_tod = (m_tod + 1) % 86400;
                m_stick = 1;
                m_dtick = (m_tod == 0);
            end
        end
    endtask

    task automatic compare_all();
        int h, m, s, h12;
        h = m_tod / 3600;
        m = (m_tod / 60) % 60;
        s = m_tod % 60;
        h12 = (h == 0) ? 12 : (h > 12) ? h - 12 : h;
        check("a_hour", a_hour, h);          check("b_hour", b_hour, h);
        check("a_minute", a_minute, m);      check("b_minute", b_minute, m);
        check("a_second", a_second, s);      check("b_second", b_second, s);
        check("a_hour_bcd", a_hour_bcd, bcd(h));
        check("b_hour_bcd", b_hour_bcd, bcd(h12));
        check("a_min_bcd", a_min_bcd, bcd(m));  check("b_min_bcd", b_min_bcd, bcd(m));
        check("a_sec_bcd", a_sec_bcd, bcd(s));  check("b_sec_bcd", b_sec_bcd, bcd(s));
        check("a_pm", a_pm, 0);              check("b_pm", b_pm, h >= 12);
        check("a_sec_tick", a_sec_tick, m_stick);  check("b_sec_tick", b_sec_tick, m_stick);
        check("a_day_tick", a_day_tick, m_dtick);  check("b_day_tick", b_day_tick, m_dtick);
        check("a_ld_err", a_ld_err, m_err);  check("b_ld_err", b_ld_err, m_err);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic load(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1, input logic [3:0] m0);
        H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0;
        LD_time = 1'b1;
        cycle();
        LD_time = 1'b0;
    endtask

    initial begin
        int dcount;
        vecs[0]  = '{2'd0, 4'd0,  4'd0, 4'd0,  1'b0, 8'h00, 8'h12, 1'b0, 8'h00};
        vecs[1]  = '{2'd1, 4'd2,  4'd0, 4'd0,  1'b0, 8'h12, 8'h12, 1'b1, 8'h00};
        vecs[2]  = '{2'd1, 4'd3,  4'd4, 4'd5,  1'b0, 8'h13, 8'h01, 1'b1, 8'h45};
        vecs[3]  = '{2'd2, 4'd4,  4'd0, 4'd0,  1'b1, 8'h13, 8'h01, 1'b1, 8'h45};
        vecs[4]  = '{2'd1, 4'd3,  4'd6, 4'd0,  1'b1, 8'h13, 8'h01, 1'b1, 8'h45};
        vecs[5]  = '{2'd1, 4'd2,  4'd0, 4'd5,  1'b0, 8'h12, 8'h12, 1'b1, 8'h05};
        vecs[6]  = '{2'd2, 4'd3,  4'd5, 4'd9,  1'b0, 8'h23, 8'h11, 1'b1, 8'h59};
        vecs[7]  = '{2'd0, 4'd9,  4'd1, 4'd0,  1'b0, 8'h09, 8'h09, 1'b0, 8'h10};
        vecs[8]  = '{2'd0, 4'd10, 4'd0, 4'd0,  1'b1, 8'h09, 8'h09, 1'b0, 8'h10};
        vecs[9]  = '{2'd0, 4'd0,  4'd5, 4'd10, 1'b1, 8'h09, 8'h09, 1'b0, 8'h10};
        vecs[10] = '{2'd1, 4'd0,  4'd0, 4'd0,  1'b0, 8'h10, 8'h10, 1'b0, 8'h00};
        vecs[11] = '{2'd0, 4'd1,  4'd0, 4'd0,  1'b0, 8'h01, 8'h01, 1'b0, 8'h00};

        // Reset state, then the first tick lands exactly TD edges after release.
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        check("rst_hour_bcd", a_hour_bcd, 8'h07);
        check("rst_min_bcd", a_min_bcd, 8'h30);
        reset = 1'b0;
        run = 1'b1;
        for (int i = 0; i < TD; i++) begin
            cycle();
            check("first_tick", a_sec_tick, (i == TD - 1));
        end
        check("first_second", a_second, 1);

        // Table of loads with frozen time.
        run = 1'b0;
        for (int i = 0; i < 12; i++) begin
            load(vecs[i].h1, vecs[i].h0, vecs[i].m1, vecs[i].m0);
            check("vec_ld_err", a_ld_err, vecs[i].err);
            check("vec_hour24", a_hour_bcd, vecs[i].h24);
            check("vec_hour12", b_hour_bcd, vecs[i].h12);
            check("vec_pm12", b_pm, vecs[i].pm12);
            check("vec_min_bcd", a_min_bcd, vecs[i].mb);
        end

        // Midnight rollover: exactly one day_tick in 60 seconds from 23:59:00.
        run = 1'b1;
        load(2'd2, 4'd3, 4'd5, 4'd9);
        dcount = 0;
        for (int i = 0; i < 60 * TD; i++) begin
            cycle();
            if (a_day_tick) dcount++;
        end
        check("day_tick_count", dcount, 1);
        check("midnight_day_tick", a_day_tick, 1);
        check("midnight_hms", {a_hour_bcd, a_min_bcd, a_sec_bcd}, 24'h000000);

        // Adjust on a tick edge drops the tick and restarts the prescaler.
        load(2'd1, 4'd0, 4'd5, 4'd9);
        repeat (58 * TD + TD - 1) cycle();
        check("pre_adj_second", a_second, 58);
        inc_min = 1'b1;
        cycle();
        inc_min = 1'b0;
        check("adj_minute", a_minute, 0);
        check("adj_hour", a_hour, 10);
        check("adj_second", a_second, 58);
        check("adj_sec_tick", a_sec_tick, 0);
        for (int i = 0; i < TD; i++) begin
            cycle();
            check("post_adj_tick", a_sec_tick, (i == TD - 1));
        end
        check("post_adj_second", a_second, 59);

        // run = 0 freezes the prescaler mid-count but adjusts still apply.
        run = 1'b0;
        load(2'd2, 4'd3, 4'd1, 4'd0);
        run = 1'b1;
        repeat (2) cycle();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("frozen_second", a_second, 0);
        end
        inc_hour = 1'b1;
        cycle();
        inc_hour = 1'b0;
        check("inc_hour_wrap", a_hour, 0);
        run = 1'b1;
        cycle();
        check("resume_no_tick", a_sec_tick, 0);
        cycle();
        check("resume_tick", a_sec_tick, 1);
        check("resume_second", a_second, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            run      = ($urandom % 8) != 0;
            LD_time  = ($urandom % 24) == 0;
            inc_hour = ($urandom % 16) == 0;
            inc_min  = ($urandom % 16) == 0;
            H_in1    = 2'($urandom);
            H_in0    = 4'($urandom % 11);
            M_in1    = 4'($urandom % 7);
            M_in0    = 4'($urandom % 11);
            cycle();
        end
        LD_time = 1'b0; inc_hour = 1'b0; inc_min = 1'b0; run = 1'b1;
        repeat (3) cycle();

        // Asynchronous reset between edges.
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_rst_hour", a_hour, 7);
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
        repeat (2 * TD) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
